rx_mac_hash_calc_mc: RTL and testbench

Multi-channel, parametrised hash engine for the rx port manager. It accepts NCH independent byte-serial key streams, such as DMAC, SMAC, or VLAN+MAC tuples. Each key is hashed with a runtime-programmable CRC-16 polynomial and seed, and the assembled key and folded hash are emitted once per key. Config changes apply only at key boundaries, and malformed keys are flagged, not hashed. It sits between the frame info extractor and the MAC lookup table.

---
 rtl/rx_mac_hash_calc_mc.sv | 190 +++++++++++++++++++
 tb/tb_rx_mac_hash_calc_mc.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_mac_hash_calc_mc.sv
// rx_mac_hash_calc_mc: multi-channel CRC-16 key hasher for the rx port manager.
// Each channel assembles a KEY_BYTES byte-serial key (soc/eoc framed), hashes it
// with a runtime-programmable CRC-16 poly/seed, and emits the key plus folded hash.
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_hash_poly_regs / i_hash_init_val_regs / i_hash_regs_vld : config, latched into shadow
//   i_data[NCH*8], i_data_vld/i_soc/i_eoc[NCH]                : per-channel key byte streams
//   o_hash_key[NCH*CWIDTH], o_key[NCH*8*KEY_BYTES]            : per-channel result, held
//   o_vld[NCH], o_err[NCH]                                    : 1-cycle result / malformed strobes
module rx_mac_hash_calc_mc #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned KEY_BYTES = 6,
  parameter int unsigned CWIDTH    = 12,
  parameter int unsigned FOLD_EN   = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [15:0]                   i_hash_poly_regs,
  input  logic [15:0]                   i_hash_init_val_regs,
  input  logic                          i_hash_regs_vld,
  input  logic [NCH*8-1:0]              i_data,
  input  logic [NCH-1:0]                i_data_vld,
  input  logic [NCH-1:0]                i_soc,
  input  logic [NCH-1:0]                i_eoc,
  output logic [NCH*CWIDTH-1:0]         o_hash_key,
  output logic [NCH*8*KEY_BYTES-1:0]    o_key,
  output logic [NCH-1:0]                o_vld,
  output logic [NCH-1:0]                o_err
);

  localparam int unsigned KW    = 8 * KEY_BYTES;
  localparam int unsigned CNT_W = $clog2(KEY_BYTES + 1);
  localparam logic [15:0] POLY_RST = 16'h1021;
  localparam logic [15:0] INIT_RST = 16'hFFFF;

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_e;

  // One CRC byte step, MSB of the byte first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b,
                                           input logic [15:0] poly);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [CWIDTH-1:0] fold_crc(input logic [15:0] crc);
    if (FOLD_EN != 0) return CWIDTH'(crc) ^ CWIDTH'(crc >> CWIDTH);
    return CWIDTH'(crc);
  endfunction

  logic [15:0] sh_poly_q, sh_init_q;
  logic [15:0] eff_poly_c, eff_init_c;

  // A strobe coinciding with soc must already be visible to that soc.
  assign eff_poly_c = i_hash_regs_vld ? i_hash_poly_regs     : sh_poly_q;
  assign eff_init_c = i_hash_regs_vld ? i_hash_init_val_regs : sh_init_q;

  // Shared shadow config.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sh_poly_q <= POLY_RST;
      sh_init_q <= INIT_RST;
    end else if (i_hash_regs_vld) begin
      sh_poly_q <= i_hash_poly_regs;
      sh_init_q <= i_hash_init_val_regs;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         crc_q, crc_d;
    logic [KW-1:0]       key_q, key_d;
    logic [15:0]         poly_q, poly_d, init_q, init_d;
    logic [CWIDTH-1:0]   hash_q, hash_d;
    logic [KW-1:0]       okey_q, okey_d;
    logic                vld_q, vld_d, err_q, err_d;

    logic [7:0]          byte_c;
    logic                beat_c, soc_c, eoc_c, last_c;
    logic [15:0]         crc_soc_c, crc_acc_c;
    logic [KW-1:0]       key_soc_c, key_acc_c;

    assign byte_c    = i_data[8*c +: 8];
    assign beat_c    = i_data_vld[c];
    assign soc_c     = i_soc[c];
    assign eoc_c     = i_eoc[c];
    // This beat is the KEY_BYTES-th byte of the key in flight.
    assign last_c    = (32'(cnt_q) + 32'd1) == KEY_BYTES;
    assign crc_soc_c = crc_step(eff_init_c, byte_c, eff_poly_c);
    assign crc_acc_c = crc_step(crc_q, byte_c, poly_q);
    assign key_soc_c = KW'(byte_c);
    assign key_acc_c = KW'({key_q, byte_c});

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state_q <= S_IDLE;
      else        state_q <= state_d;
    end

    // Next state.
    always_comb begin
      state_d = state_q;
      if (beat_c) begin
        if (soc_c)                                   state_d = eoc_c ? S_IDLE : S_ACC;
        else if (state_q == S_ACC && (eoc_c || last_c)) state_d = S_IDLE;
      end
    end

    // Datapath and result next values; an aborting soc reports err and restarts.
    always_comb begin
      cnt_d  = cnt_q;
      crc_d  = crc_q;
      key_d  = key_q;
      poly_d = poly_q;
      init_d = init_q;
      hash_d = hash_q;
      okey_d = okey_q;
      vld_d  = 1'b0;
      err_d  = 1'b0;
      if (beat_c) begin
        if (soc_c) begin
          poly_d = eff_poly_c;
          init_d = eff_init_c;
          crc_d  = crc_soc_c;
          key_d  = key_soc_c;
          cnt_d  = CNT_W'(1);
          if (eoc_c) begin
            if (KEY_BYTES == 32'd1) begin
              hash_d = fold_crc(crc_soc_c);
              okey_d = key_soc_c;
              vld_d  = 1'b1;
            end else begin
              err_d  = 1'b1;
            end
          end else if (state_q == S_ACC) begin
            err_d = 1'b1;
          end
        end else if (state_q == S_ACC) begin
          crc_d = crc_acc_c;
          key_d = key_acc_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (eoc_c && last_c) begin
            hash_d = fold_crc(crc_acc_c);
            okey_d = key_acc_c;
            vld_d  = 1'b1;
          end else if (eoc_c || last_c) begin
            err_d  = 1'b1;
          end
        end
      end
    end

    // Datapath registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        cnt_q  <= '0;
        crc_q  <= '0;
        key_q  <= '0;
        poly_q <= POLY_RST;
        init_q <= INIT_RST;
        hash_q <= '0;
        okey_q <= '0;
        vld_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        crc_q  <= crc_d;
        key_q  <= key_d;
        poly_q <= poly_d;
        init_q <= init_d;
        hash_q <= hash_d;
        okey_q <= okey_d;
        vld_q  <= vld_d;
        err_q  <= err_d;
      end
    end

    assign o_hash_key[c*CWIDTH +: CWIDTH] = hash_q;
    assign o_key[c*KW +: KW]              = okey_q;
    assign o_vld[c]                       = vld_q;
    assign o_err[c]                       = err_q;
  end

endmodule

// File: tb/tb_rx_mac_hash_calc_mc.sv
// Bench for rx_mac_hash_calc_mc: three instances (9-byte folded, 9-byte truncated,
// default 6-byte) share one stimulus stream and are checked every cycle against a
// key-level reference model, plus literal expectations for known keys.
`timescale 1ns/100ps
module tb_rx_mac_hash_calc_mc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  poly_i, init_i;
  logic         regs_vld;
  logic [15:0]  data;
  logic [1:0]   dvld, soc, eoc;

  logic [23:0]  h9, h9t, h6;
  logic [143:0] k9, k9t;
  logic [95:0]  k6;
  logic [1:0]   v9, e9, v9t, e9t, v6, e6;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rx_mac_hash_calc_mc #(.NCH(2), .KEY_BYTES(9), .CWIDTH(12), .FOLD_EN(1)) u_k9 (
    .i_clk(clk), .i_rst(rst_n), .i_hash_poly_regs(poly_i), .i_hash_init_val_regs(init_i),
    .i_hash_regs_vld(regs_vld), .i_data(data), .i_data_vld(dvld), .i_soc(soc), .i_eoc(eoc),
    .o_hash_key(h9), .o_key(k9), .o_vld(v9), .o_err(e9));

  rx_mac_hash_calc_mc #(.NCH(2), .KEY_BYTES(9), .CWIDTH(12), .FOLD_EN(0)) u_k9t (
    .i_clk(clk), .i_rst(rst_n), .i_hash_poly_regs(poly_i), .i_hash_init_val_regs(init_i),
    .i_hash_regs_vld(regs_vld), .i_data(data), .i_data_vld(dvld), .i_soc(soc), .i_eoc(eoc),
    .o_hash_key(h9t), .o_key(k9t), .o_vld(v9t), .o_err(e9t));

  rx_mac_hash_calc_mc u_k6 (
    .i_clk(clk), .i_rst(rst_n), .i_hash_poly_regs(poly_i), .i_hash_init_val_regs(init_i),
    .i_hash_regs_vld(regs_vld), .i_data(data), .i_data_vld(dvld), .i_soc(soc), .i_eoc(eoc),
    .o_hash_key(h6), .o_key(k6), .o_vld(v6), .o_err(e6));

  // ---------------- reference model ----------------
  int kb_a   [3] = '{9, 9, 6};
  int fold_a [3] = '{1, 0, 1};

  logic [15:0]  sh_poly, sh_init;
  bit           m_act  [3][2];
  int           m_cnt  [3][2];
  logic [143:0] m_key  [3][2];
  logic [15:0]  m_poly [3][2];
  logic [15:0]  m_init [3][2];
  logic [15:0]  x_hash [3][2];
  logic [143:0] x_key  [3][2];
  logic         x_vld  [3][2];
  logic         x_err  [3][2];

  // CRC of an n-byte message held right-aligned in msg, first byte most significant.
  function automatic logic [15:0] crc_msg(input logic [15:0] seed, input logic [15:0] poly,
                                          input logic [143:0] msg, input int n);
    logic [15:0] r;
    logic        fb;
    r = seed;
    for (int j = 8*n - 1; j >= 0; j--) begin
      fb = r[15] ^ msg[j];
      r  = (r << 1) ^ (fb ? poly : 16'h0000);
    end
    return r;
  endfunction

  function automatic logic [15:0] fold12(input logic [15:0] crc, input int fold);
    if (fold != 0) return (crc % 16'd4096) ^ (crc / 16'd4096);
    return crc % 16'd4096;
  endfunction

  task automatic model_step();
    logic [15:0] ep, ei;
    logic [7:0]  b;
    if (!rst_n) begin
      sh_poly = 16'h1021;
      sh_init = 16'hFFFF;
      for (int i = 0; i < 3; i++)
        for (int c = 0; c < 2; c++) begin
          m_act[i][c] = 0;  m_cnt[i][c] = 0;  m_key[i][c] = '0;
          x_hash[i][c] = '0; x_key[i][c] = '0; x_vld[i][c] = 0; x_err[i][c] = 0;
        end
      return;
    end
    ep = regs_vld ? poly_i : sh_poly;
    ei = regs_vld ? init_i : sh_init;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 2; c++) begin
        x_vld[i][c] = 0;
        x_err[i][c] = 0;
        if (dvld[c]) begin
          b = data[8*c +: 8];
          if (soc[c]) begin
            if (m_act[i][c]) x_err[i][c] = 1;
            m_poly[i][c] = ep;
            m_init[i][c] = ei;
            m_key[i][c]  = 144'(b);
            m_cnt[i][c]  = 1;
            m_act[i][c]  = 1;
            if (eoc[c]) begin
              m_act[i][c] = 0;
              x_err[i][c] = 1;
            end
          end else if (m_act[i][c]) begin
            m_key[i][c] = (m_key[i][c] << 8) | 144'(b);
            m_cnt[i][c] = m_cnt[i][c] + 1;
            if (eoc[c] && m_cnt[i][c] == kb_a[i]) begin
              m_act[i][c]  = 0;
              x_hash[i][c] = fold12(crc_msg(m_init[i][c], m_poly[i][c], m_key[i][c], m_cnt[i][c]),
                                    fold_a[i]);
              x_key[i][c]  = m_key[i][c];
              x_vld[i][c]  = 1;
            end else if (eoc[c] || m_cnt[i][c] == kb_a[i]) begin
              m_act[i][c] = 0;
              x_err[i][c] = 1;
            end
          end
        end
      end
    if (regs_vld) begin
      sh_poly = poly_i;
      sh_init = init_i;
    end
  endtask

  task automatic check(input string name, input int i, input int c,
                       input logic [143:0] act, input logic [143:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d ch%0d got %h expected %h", name, i, c, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [143:0] ah, ak;
    logic         av, ae;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 2; c++) begin
        if (i == 0) begin
          ah = 144'(h9[c*12 +: 12]);  ak = 144'(k9[c*72 +: 72]);  av = v9[c];  ae = e9[c];
        end else if (i == 1) begin
          ah = 144'(h9t[c*12 +: 12]); ak = 144'(k9t[c*72 +: 72]); av = v9t[c]; ae = e9t[c];
        end else begin
          ah = 144'(h6[c*12 +: 12]);  ak = 144'(k6[c*48 +: 48]);  av = v6[c];  ae = e6[c];
        end
        check("hash", i, c, ah, 144'(x_hash[i][c]));
        check("key",  i, c, ak, x_key[i][c]);
        check("vld",  i, c, 144'(av), 144'(x_vld[i][c]));
        check("err",  i, c, 144'(ae), 144'(x_err[i][c]));
      end
  endtask

  // Per-cycle scoreboard: update model at the edge, compare just after it.
  always @(posedge clk) begin
    model_step();
    #1;
    compare_all();
  end

  // ---------------- stimulus ----------------
  task automatic beat(input logic [1:0] v, input logic [15:0] d,
                      input logic [1:0] s, input logic [1:0] e);
    @(negedge clk);
    dvld = v; data = d; soc = s; eoc = e; regs_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(2'b00, 16'h0000, 2'b00, 2'b00);
  endtask

  task automatic strobe_now(input logic [15:0] p, input logic [15:0] iv);
    poly_i = p; init_i = iv; regs_vld = 1'b1;
  endtask

  // n bytes of key on channel ch; soc/eoc at byte indices soc_at/eoc_at (-1 = none).
  task automatic send_key(input int ch, input logic [143:0] key, input int n,
                          input int soc_at, input int eoc_at, input int gap);
    logic [1:0] m;
    logic [7:0] b;
    m = 2'b01 << ch;
    for (int k = 0; k < n; k++) begin
      b = key[8*(n-1-k) +: 8];
      beat(m, 16'(b) << (8*ch), (k == soc_at) ? m : 2'b00, (k == eoc_at) ? m : 2'b00);
      if (gap > 0 && k < n - 1) idle(gap);
    end
  endtask

  logic [143:0] s9;

  initial begin
    s9 = 144'h313233343536373839;
    rst_n = 1'b1; poly_i = 16'h0; init_i = 16'h0; regs_vld = 1'b0;
    data = '0; dvld = '0; soc = '0; eoc = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_vld",  0, 0, 144'(v9), 144'(0));
    check("rst_hash", 0, 0, 144'(h9), 144'(0));
    check("rst_key",  2, 0, 144'(k6), 144'(0));
    check("model_crc", 0, 0, 144'(crc_msg(16'hFFFF, 16'h1021, s9, 9)), 144'(16'h29B1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // "123456789" on ch0 with default config
    send_key(0, s9, 9, 0, 8, 0);
    idle(1);
    check("k9_vld",  0, 0, 144'(v9[0]), 144'(1));
    check("k9_hash", 0, 0, 144'(h9[11:0]), 144'(12'h9B3));
    check("k9t_hash", 1, 0, 144'(h9t[11:0]), 144'(12'h9B1));
    check("k9_key",  0, 0, 144'(k9[71:0]), s9);
    idle(2);

    // same key with bubbles; "123456" on ch1 concurrently-ish afterwards
    send_key(0, s9, 9, 0, 8, 2);
    idle(1);
    check("bub_hash", 0, 0, 144'(h9[11:0]), 144'(12'h9B3));
    check("bub_vld",  0, 0, 144'(v9[0]), 144'(1));
    send_key(1, 144'h313233343536, 6, 0, 5, 1);
    idle(2);

    // init = 0, six zero bytes on both channels together
    idle(1); strobe_now(16'h1021, 16'h0000);
    for (int k = 0; k < 6; k++) beat(2'b11, 16'h0000, (k == 0) ? 2'b11 : 2'b00, (k == 5) ? 2'b11 : 2'b00);
    idle(1);
    check("zero_vld",  2, 0, 144'(v6), 144'(2'b11));
    check("zero_hash", 2, 0, 144'(h6), 144'(0));
    check("zero_key",  2, 0, 144'(k6), 144'(0));
    check("zero_k9err", 0, 0, 144'(e9), 144'(2'b11));
    idle(2);

    // mid-key strobe: current key keeps 0xFFFF seed, next key sees 0x0000
    idle(1); strobe_now(16'h1021, 16'hFFFF);
    idle(1);
    for (int k = 0; k < 6; k++) begin
      beat(2'b01, 16'(8'h41 + 8'(k)), (k == 0) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00);
      if (k == 2) strobe_now(16'h1021, 16'h0000);
    end
    idle(1);
    send_key(0, 144'h0, 6, 0, 5, 0);
    idle(1);
    check("newseed_hash", 2, 0, 144'(h6[11:0]), 144'(0));
    check("newseed_vld",  2, 0, 144'(v6[0]), 144'(1));
    // strobe on the soc beat applies to that key
    beat(2'b01, 16'h00AA, 2'b01, 2'b00); strobe_now(16'h8005, 16'h1D0F);
    send_key(0, 144'h0102030405, 5, -1, 4, 0);
    idle(2);

    // eoc on 4th byte
    send_key(0, 144'h11223344, 4, 0, 3, 0);
    idle(1);
    check("short_err", 2, 0, 144'(e6[0]), 144'(1));
    check("short_vld", 2, 0, 144'(v6[0]), 144'(0));
    idle(1);

    // seven bytes without eoc: err after 6th, 7th ignored
    send_key(0, 144'hA1A2A3A4A5A6, 6, 0, -1, 0);
    beat(2'b01, 16'h00A7, 2'b00, 2'b00);
    check("long_err", 2, 0, 144'(e6[0]), 144'(1));
    idle(1);
    check("long_quiet", 2, 0, 144'({v6[0], e6[0]}), 144'(0));
    idle(1);

    // soc at byte 3: err then clean restart
    send_key(0, 144'hC1C2, 2, 0, -1, 0);
    send_key(0, 144'hD1D2D3D4D5D6, 6, 0, 5, 0);
    idle(1);
    check("restart_vld", 2, 0, 144'(v6[0]), 144'(1));
    check("restart_key", 2, 0, 144'(k6[47:0]), 144'h0000D1D2D3D4D5D6);
    idle(1);

    // reset mid-key with non-default config programmed
    idle(1); strobe_now(16'h8005, 16'h0000);
    send_key(0, s9, 3, 0, -1, 0);
    #1 rst_n = 1'b0; dvld = '0; soc = '0; eoc = '0;
    #1;
    check("arst_k6", 2, 0, 144'({h6, k6, v6, e6}), 144'(0));
    check("arst_k9", 0, 0, 144'({h9, v9, e9}), 144'(0));
    check("arst_k9key", 0, 0, k9, 144'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_key(0, s9, 9, 0, 8, 0);
    idle(1);
    check("post_rst_hash", 0, 0, 144'(h9[11:0]), 144'(12'h9B3));
    check("post_rst_vld",  0, 0, 144'(v9[0]), 144'(1));
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
